// File: rtl/qsys_pulse_out.sv
// Avalon-MM output port: level register plus per-bit one-shot pulses, done-capture and masked irq.
// Writes take effect the edge they are sampled; readdata is registered one cycle after address.
module qsys_pulse_out #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  output logic [WIDTH-1:0] out_port
);

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] done_cap;
  logic [WIDTH-1:0] pulse_active;
  logic [WIDTH-1:0] active_nxt;
  logic [WIDTH-1:0] done_set;
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] w1c;
  logic [CNT_W-1:0] pulse_len;
  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [31:0]      rd_nxt;
  logic             unused_wd;

  assign wr        = chipselect && !write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign start     = (wr && address == 3'd6) ? wd : '0;
  assign w1c       = (wr && address == 3'd3) ? wd : '0;

  assign out_port = data_reg | pulse_active;
  assign irq      = |(done_cap & irq_mask);

  // A non-zero start (re)loads the counter and suppresses the done of an ending pulse;
  // a zero-length start only records done and leaves a running pulse alone.
  always_comb begin
    active_nxt = pulse_active;
    done_set   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt[i];
      if (start[i] && pulse_len != '0) begin
        active_nxt[i] = 1'b1;
        cnt_nxt[i]    = pulse_len;
      end else begin
        if (start[i]) begin
          done_set[i] = 1'b1;
        end
        if (pulse_active[i]) begin
          if (cnt[i] == CNT_W'(1)) begin
            active_nxt[i] = 1'b0;
            cnt_nxt[i]    = '0;
            done_set[i]   = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] - CNT_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    rd_nxt = '0;
    case (address)
      3'd0:    rd_nxt[WIDTH-1:0] = data_reg;
      3'd1:    rd_nxt[CNT_W-1:0] = pulse_len;
      3'd2:    rd_nxt[WIDTH-1:0] = irq_mask;
      3'd3:    rd_nxt[WIDTH-1:0] = done_cap;
      3'd6:    rd_nxt[WIDTH-1:0] = pulse_active;
      default: rd_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg     <= '0;
      pulse_len    <= CNT_W'(1);
      irq_mask     <= '0;
      done_cap     <= '0;
      pulse_active <= '0;
      readdata     <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      readdata     <= rd_nxt;
      pulse_active <= active_nxt;
      // set wins over a same-cycle write-1-to-clear
      done_cap     <= (done_cap & ~w1c) | done_set;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      if (wr) begin
        case (address)
          3'd0:    data_reg  <= wd;
          3'd1:    pulse_len <= writedata[CNT_W-1:0];
          3'd2:    irq_mask  <= wd;
          3'd4:    data_reg  <= data_reg | wd;
          3'd5:    data_reg  <= data_reg & ~wd;
          default: ;
        endcase
      end
    end
  end

endmodule
